// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and state types for the sequential ALU (ALU_MUL_EN selects the MUL encoding)
package alu_pkg;

`ifdef ALU_MUL_EN
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_ADC   = 3'd5,
        OP_SHIFT = 3'd6,
        OP_MUL   = 3'd7
    } alu_op_e;
`else
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_ADC = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;
`endif

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL
    } alu_state_e;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU ops (ADD/SUB/AND/OR/XOR/ADC) with N/V/Z/C flags
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in && (op == OP_ADC)};
        diff = {1'b0, a} - {1'b0, b};
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_op_e'(op))
            OP_ADD, OP_ADC: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            // C is "no borrow": set when a >= b
            OP_SUB: begin
                r = diff[WIDTH-1:0];
                c = ~diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        result  = r;
        flags.n = r[WIDTH-1];
        flags.v = v;
        flags.z = (r == '0);
        flags.c = c;
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with persistent carry, iterative shift and optional multiply (ALU_MUL_EN)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);

    alu_state_e       state;
    alu_flags_t       flags;
    alu_flags_t       comb_f;
    logic [WIDTH-1:0] comb_r;
    logic             carry_reg;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] sh;
    logic             sh_right;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic             accept;
    logic             is_shift;
    logic             shift_right;
    logic [SHW-1:0]   amt;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (a),
        .b        (b),
        .op       (op),
        .carry_in (carry_reg),
        .result   (comb_r),
        .flags    (comb_f)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign amt      = b[SHW-1:0];
    assign busy     = (state != ST_IDLE);
    assign {flag_n, flag_v, flag_z, flag_c} = flags;

`ifdef ALU_MUL_EN
    localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);

    logic             is_mul;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH:0]   add_hi;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    assign is_shift    = (op == OP_SHIFT);
    assign shift_right = b[WIDTH-1];
    assign is_mul      = (op == OP_MUL);

    // One shift-add step: conditionally add the multiplicand, then shift {hi,lo} right
    always_comb begin
        add_hi             = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
        {hi_next, lo_next} = {add_hi, prod_lo[WIDTH-1:1]};
    end
`else
    assign is_shift    = (op == OP_SHL) || (op == OP_SHR);
    assign shift_right = (op == OP_SHR);
`endif

    always_comb begin
        sh_next = sh_right ? (sh >> 1) : (sh << 1);
        sh_out  = sh_right ? sh[0] : sh[WIDTH-1];
    end

    function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c);
        alu_flags_t f;
        f.n = r[WIDTH-1];
        f.v = 1'b0;
        f.z = (r == '0);
        f.c = c;
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            sh_right  <= 1'b0;
`ifdef ALU_MUL_EN
            mcand     <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            if (amt == '0) begin
                                result    <= a;
                                flags     <= mk_flags(a, 1'b0);
                                carry_reg <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                sh       <= a;
                                sh_right <= shift_right;
                                cnt      <= {1'b0, amt};
                                state    <= ST_SHIFT;
                            end
                        end
`ifdef ALU_MUL_EN
                        else if (is_mul) begin
                            mcand   <= a;
                            prod_hi <= '0;
                            prod_lo <= b;
                            cnt     <= MUL_ITERS;
                            state   <= ST_MUL;
                        end
`endif
                        else begin
                            result    <= comb_r;
                            flags     <= comb_f;
                            carry_reg <= comb_f.c;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh  <= sh_next;
                    cnt <= cnt - (SHW+1)'(1);
                    if (cnt == (SHW+1)'(1)) begin
                        result    <= sh_next;
                        flags     <= mk_flags(sh_next, sh_out);
                        carry_reg <= sh_out;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    prod_hi <= hi_next;
                    prod_lo <= lo_next;
                    cnt     <= cnt - (SHW+1)'(1);
                    if (cnt == (SHW+1)'(1)) begin
                        result    <= lo_next;
                        flags     <= mk_flags(lo_next, |hi_next);
                        carry_reg <= |hi_next;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=8), directed vectors, either ALU_MUL_EN build
module tb_alu_seq;

    localparam logic [2:0] OPC_ADD = 3'd0;
    localparam logic [2:0] OPC_SUB = 3'd1;
    localparam logic [2:0] OPC_AND = 3'd2;
    localparam logic [2:0] OPC_OR  = 3'd3;
    localparam logic [2:0] OPC_XOR = 3'd4;
    localparam logic [2:0] OPC_ADC = 3'd5;
    localparam logic [2:0] OPC_SHL = 3'd6;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OPC_SHR = 3'd6;
    localparam logic [7:0] SHR_B   = 8'h80;
    localparam logic [2:0] OPC_MUL = 3'd7;
`else
    localparam logic [2:0] OPC_SHR = 3'd7;
    localparam logic [7:0] SHR_B   = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_n, flag_v, flag_z, flag_c;
    logic       busy;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Presents one op, waits for acceptance and queues the expected response.
    task automatic issue(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] er, input logic [3:0] ef, input int lat,
                         input bit push, output int waitc);
        logic ok;
        int   t;
        waitc    = 0;
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        do begin
            @(negedge clk);
            ok = in_ready;
            t  = cyc;
            @(posedge clk);
            #1;
            waitc++;
        end while (!ok && waitc < 200);
        in_valid = 1'b0;
        if (!ok)
            chk("accept_timeout", 32'(ok), 32'd1);
        else if (push)
            sb.push_back('{r: er, f: ef, cyc: t + lat});
    endtask

    task automatic run(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] er, input logic [3:0] ef, input int lat);
        int w;
        issue(o, aa, bb, er, ef, lat, 1'b1, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: time-stamp each new result, compare it when it is consumed.
    initial begin
        bit   stamped = 1'b0;
        int   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stamped = 1'b0;
            end else begin
                if (out_valid && !stamped) begin
                    stamped = 1'b1;
                    seen    = cyc;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h with nothing expected (cycle %0d)", result, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(result), 32'(e.r));
                        chk("flags_nvzc", 32'({flag_n, flag_v, flag_z, flag_c}), 32'(e.f));
                        chk("out_valid_cycle", 32'(seen), 32'(e.cyc));
                    end
                    stamped = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        int nbusy;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({out_valid, in_ready, busy, result, flag_n, flag_v, flag_z, flag_c}),
            32'({1'b0, 1'b1, 1'b0, 8'h00, 4'b0000}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(OPC_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1);
        run(OPC_ADC, 8'h10, 8'h20, 8'h31, 4'b0000, 1);
        run(OPC_SUB, 8'h05, 8'h05, 8'h00, 4'b0011, 1);
        run(OPC_SUB, 8'h03, 8'h08, 8'hFB, 4'b1000, 1);
        run(OPC_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
        run(OPC_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
        run(OPC_ADC, 8'h01, 8'h01, 8'h02, 4'b0000, 1);
        run(OPC_OR,  8'h00, 8'h00, 8'h00, 4'b0010, 1);
        run(OPC_XOR, 8'hF0, 8'h0F, 8'hFF, 4'b1000, 1);

        run(OPC_SHL, 8'h81, 8'h03, 8'h08, 4'b0000, 4);
        nbusy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        chk("busy_cycles_shl3", 32'(nbusy), 32'd3);
        @(posedge clk);
        #1;
        run(OPC_SHR, 8'h81, 8'h01 | SHR_B, 8'h40, 4'b0001, 2);
        run(OPC_SHL, 8'h80, 8'h00, 8'h80, 4'b1000, 1);
        run(OPC_SHR, 8'h80, 8'h07 | SHR_B, 8'h01, 4'b0000, 8);
`ifdef ALU_MUL_EN
        run(OPC_MUL, 8'h12, 8'h10, 8'h20, 4'b0001, 9);
        run(OPC_MUL, 8'h0F, 8'h0F, 8'hE1, 4'b1000, 9);
`endif
        drain();

        // Backpressure: result must hold and a pending op must wait
        out_ready = 1'b0;
        run(OPC_XOR, 8'h5A, 8'h0F, 8'h55, 4'b0000, 1);
        in_valid = 1'b1;
        op       = OPC_ADD;
        a        = 8'h01;
        b        = 8'h02;
        repeat (5) begin
            @(negedge clk);
            chk("hold_state", 32'({out_valid, in_ready, result, flag_n, flag_v, flag_z, flag_c}),
                32'({1'b1, 1'b0, 8'h55, 4'b0000}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OPC_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1, 1'b1, w);
        chk("release_accept_cycles", 32'(w), 32'd1);

        // Reset mid-shift after an op that left carry set
        run(OPC_SHR, 8'h81, 8'h01 | SHR_B, 8'h40, 4'b0001, 2);
        drain();
        issue(OPC_SHL, 8'h81, 8'h05, 8'h00, 4'b0000, 6, 1'b0, w);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_mid_shift", 32'({out_valid, in_ready, busy, result, flag_n, flag_v, flag_z, flag_c}),
            32'({1'b0, 1'b1, 1'b0, 8'h00, 4'b0000}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        run(OPC_ADC, 8'hFF, 8'h00, 8'hFF, 4'b1000, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
